// File: rtl/dc_data_buffer_be.sv
// Write-domain storage array for the dual-clock AXI slice: byte-strobed writes through an
// owned one-hot write pointer, one-hot read decode with optional output register.
module dc_data_buffer_be #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned BUFFER_DEPTH = 8,
  parameter int unsigned OUTPUT_REG   = 0
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      clear,
  input  logic                      write_en,
  input  logic [DATA_WIDTH/8-1:0]   write_strb,
  input  logic [DATA_WIDTH-1:0]     write_data,
  output logic [BUFFER_DEPTH-1:0]   write_pointer,
  input  logic [BUFFER_DEPTH-1:0]   read_pointer,
  output logic [DATA_WIDTH-1:0]     read_data,
  output logic                      ptr_error
);

  localparam int unsigned STRB_W = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0]   mem_q [BUFFER_DEPTH];
  logic [DATA_WIDTH-1:0]   mem_d [BUFFER_DEPTH];
  logic [BUFFER_DEPTH-1:0] wptr_q, wptr_d;
  logic                    ptr_error_q, ptr_error_d;

  logic                    rd_onehot_c;
  logic [DATA_WIDTH-1:0]   rd_mux_c;
  logic [DATA_WIDTH-1:0]   rd_sel_c;

  // Write path: clear beats write; the pointer advances even with an all-zero strobe.
  always_comb begin
    mem_d  = mem_q;
    wptr_d = wptr_q;
    if (clear) begin
      wptr_d = BUFFER_DEPTH'(1);
    end else if (write_en) begin
      for (int unsigned s = 0; s < BUFFER_DEPTH; s++) begin
        if (wptr_q[s]) begin
          for (int unsigned b = 0; b < STRB_W; b++) begin
            if (write_strb[b]) begin
              mem_d[s][8*b +: 8] = write_data[8*b +: 8];
            end
          end
        end
      end
      wptr_d = {wptr_q[BUFFER_DEPTH-2:0], wptr_q[BUFFER_DEPTH-1]};
    end
  end

  // Read decode: anything other than exactly one set bit reads as zero and flags an error.
  always_comb begin
    rd_onehot_c = (read_pointer != '0) &&
                  ((read_pointer & (read_pointer - BUFFER_DEPTH'(1))) == '0);
    rd_mux_c    = '0;
    for (int unsigned s = 0; s < BUFFER_DEPTH; s++) begin
      if (read_pointer[s]) begin
        rd_mux_c = rd_mux_c | mem_q[s];
      end
    end
    rd_sel_c    = rd_onehot_c ? rd_mux_c : '0;
    ptr_error_d = ptr_error_q | ~rd_onehot_c;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int unsigned s = 0; s < BUFFER_DEPTH; s++) begin
        mem_q[s] <= '0;
      end
      wptr_q      <= BUFFER_DEPTH'(1);
      ptr_error_q <= 1'b0;
    end else begin
      for (int unsigned s = 0; s < BUFFER_DEPTH; s++) begin
        mem_q[s] <= mem_d[s];
      end
      wptr_q      <= wptr_d;
      ptr_error_q <= ptr_error_d;
    end
  end

  assign write_pointer = wptr_q;
  assign ptr_error     = ptr_error_q;

  if (OUTPUT_REG != 0) begin : g_oreg
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

    assign rdata_d = rd_sel_c;

    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        rdata_q <= '0;
      end else begin
        rdata_q <= rdata_d;
      end
    end

    assign read_data = rdata_q;
  end else begin : g_ocomb
    assign read_data = rd_sel_c;
  end

endmodule
